// File: rtl/blaster_rx_if.sv
// Serial-line bundle for the blaster UART receiver.
// slave: the receiver itself; master: the line driver / byte consumer side.
interface blaster_rx_if;
    logic       i_rx_pin;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    modport slave (
        input  i_rx_pin,
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_busy
    );

    modport master (
        output i_rx_pin,
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_busy
    );
endinterface

// File: rtl/blaster_rx.sv
// 8N1 UART receiver for the blaster link: mid-bit sampling, 1-cycle valid/frame-error strobes.
// Optional even-parity (8E1) frame when BLASTER_RX_PARITY_EN is defined.
module blaster_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic          i_clk,
    input  logic          reset,
    blaster_rx_if.slave   rx_if
);

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef BLASTER_RX_PARITY_EN
        S_PARITY  = 3'd6,
`endif
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4,
        S_BREAK   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;
`ifdef BLASTER_RX_PARITY_EN
    logic                par_err_q, par_err_d;
`endif

    // State, datapath and output registers; synchronizer resets to idle-high.
    always_ff @(posedge i_clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef BLASTER_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_if.i_rx_pin;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef BLASTER_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Next-state and output decode; strobes default low so they last one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef BLASTER_RX_PARITY_EN
        par_err_d = par_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) state_d = S_START;
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'd1);
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef BLASTER_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'd1);
                end
            end

`ifdef BLASTER_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = rx_s_q ^ (^shift_q);
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'd1);
                end
            end
`endif

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
`ifdef BLASTER_RX_PARITY_EN
                        if (par_err_q) begin
                            ferr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = shift_q;
                        valid_d = 1'b1;
`endif
                        state_d = S_CLEANUP;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'd1);
                end
            end

            S_CLEANUP: state_d = S_IDLE;

            // Held-low line must return high before another start is accepted.
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign rx_if.o_data      = data_q;
    assign rx_if.o_valid     = valid_q;
    assign rx_if.o_frame_err = ferr_q;
    assign rx_if.o_busy      = busy_q;

endmodule
